// File: rtl/reg_view_scan.sv
// reg_view_scan: selectable register-file viewer with hex 7-segment scan.
// Optional AUTO_SCROLL_EN adds input auto_scroll and parameter AUTO_DIV.
module reg_view_scan #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
`ifdef AUTO_SCROLL_EN
  parameter int AUTO_DIV   = 50000000,
`endif
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef AUTO_SCROLL_EN
  input  logic                     auto_scroll,
`endif
  input  logic [NUM_REGS*XLEN-1:0] reg_flat,
  input  logic                     tick_r,
  input  logic                     tick_l,
  output logic [XLEN-1:0]          data_reg,
  output logic [IDX_W-1:0]         leds,
  output logic [NUM_DIGITS-1:0]    an,
  output logic [6:0]               seg
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NIB   = (XLEN + 3) / 4;
  localparam int PAD_W = NIB * 4;
  localparam int NSHOW = (NIB < NUM_DIGITS) ? NIB : NUM_DIGITS;

  logic [IDX_W-1:0] idx, idx_nxt;
  logic             tick_r_q, tick_l_q;
  logic             inc, dec;
  logic [DIV_W-1:0] div;
  logic [DIG_W-1:0] digit;
  logic [XLEN-1:0]  sel;
  logic [PAD_W-1:0] pad;
  logic [3:0]       nib;
  logic             blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign inc  = tick_r & ~tick_r_q;
  assign dec  = tick_l & ~tick_l_q;
  assign leds = idx;

  always_comb begin
    sel = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (idx == IDX_W'(r)) sel = reg_flat[r*XLEN +: XLEN];
  end

`ifdef AUTO_SCROLL_EN
  localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_step;

  assign auto_step = auto_scroll &&
                     (auto_cnt == AUTO_W'(AUTO_DIV - 1));

  // A manual edge wins over a coincident auto step and restarts the timer.
  always_ff @(posedge clk) begin
    if (rst || !auto_scroll || inc || dec || auto_step)
      auto_cnt <= '0;
    else
      auto_cnt <= auto_cnt + AUTO_W'(1);
  end
`endif

  always_comb begin
    idx_nxt = idx;
    if (inc && !dec)
      idx_nxt = (idx == IDX_W'(NUM_REGS - 1)) ? '0 : idx + IDX_W'(1);
    else if (dec && !inc)
      idx_nxt = (idx == '0) ? IDX_W'(NUM_REGS - 1) : idx - IDX_W'(1);
`ifdef AUTO_SCROLL_EN
    else if (!inc && !dec && auto_step)
      idx_nxt = (idx == IDX_W'(NUM_REGS - 1)) ? '0 : idx + IDX_W'(1);
`endif
  end

  assign pad = PAD_W'(data_reg);

  // Digits above the register width stay blank but keep their anode.
  always_comb begin
    nib   = 4'h0;
    blank = 1'b1;
    for (int i = 0; i < NSHOW; i++)
      if (digit == DIG_W'(i)) begin
        nib   = pad[4*i +: 4];
        blank = 1'b0;
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      tick_r_q <= 1'b0;
      tick_l_q <= 1'b0;
      data_reg <= '0;
      div      <= '0;
      digit    <= '0;
      an       <= '1;
      seg      <= 7'h7F;
    end else begin
      idx      <= idx_nxt;
      tick_r_q <= tick_r;
      tick_l_q <= tick_l;
      data_reg <= sel;
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div   <= '0;
        digit <= (digit == DIG_W'(NUM_DIGITS - 1)) ?
                 '0 : digit + DIG_W'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
      an  <= ~(NUM_DIGITS'(1) << digit);
      seg <= blank ? 7'h7F : hex7(nib);
    end
  end

endmodule

// File: tb/tb_reg_view_scan.sv
// tb_reg_view_scan: directed checks of index stepping, latching and scan.
// Build with AUTO_SCROLL_EN defined to cover auto scrolling as well.
module tb_reg_view_scan;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick_r_a, tick_l_a, tick_r_b, tick_l_b;
  logic         auto_scroll;
  logic [31:0]  regs_a [10];
  logic [9:0]   regs_b [5];
  logic [319:0] flat_a;
  logic [49:0]  flat_b;
  logic [31:0]  data_a;
  logic [3:0]   leds_a;
  logic [7:0]   an_a;
  logic [6:0]   seg_a;
  logic [9:0]   data_b;
  logic [2:0]   leds_b;
  logic [3:0]   an_b;
  logic [6:0]   seg_b;
  logic [6:0]   hex [16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    flat_a = '0;
    for (int r = 0; r < 10; r++) flat_a[r*32 +: 32] = regs_a[r];
  end

  always_comb begin
    flat_b = '0;
    for (int r = 0; r < 5; r++) flat_b[r*10 +: 10] = regs_b[r];
  end

  reg_view_scan #(
    .XLEN(32), .NUM_REGS(10), .NUM_DIGITS(8), .SCAN_DIV(4)
`ifdef AUTO_SCROLL_EN
    , .AUTO_DIV(10)
`endif
  ) dut_a (
    .clk(clk),
    .rst(rst),
`ifdef AUTO_SCROLL_EN
    .auto_scroll(auto_scroll),
`endif
    .reg_flat(flat_a),
    .tick_r(tick_r_a),
    .tick_l(tick_l_a),
    .data_reg(data_a),
    .leds(leds_a),
    .an(an_a),
    .seg(seg_a)
  );

  reg_view_scan #(
    .XLEN(10), .NUM_REGS(5), .NUM_DIGITS(4), .SCAN_DIV(1)
`ifdef AUTO_SCROLL_EN
    , .AUTO_DIV(10)
`endif
  ) dut_b (
    .clk(clk),
    .rst(rst),
`ifdef AUTO_SCROLL_EN
    .auto_scroll(1'b0),
`endif
    .reg_flat(flat_b),
    .tick_r(tick_r_b),
    .tick_l(tick_l_b),
    .data_reg(data_b),
    .leds(leds_b),
    .an(an_b),
    .seg(seg_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_r_a();
    tick_r_a = 1'b1;
    cyc(1);
    tick_r_a = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [7:0]  ea;
    logic [3:0]  eb;
    logic [11:0] pb;
    int k;
    int n;

    hex = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    regs_a[0] = 32'h89ABCDEF;
    for (int r = 1; r < 10; r++) regs_a[r] = 32'hA5000000 | r;
    regs_b[0] = 10'h2A5;
    for (int r = 1; r < 5; r++) regs_b[r] = 10'h100 | 10'(r);
    rst = 1'b1;
    tick_r_a = 1'b0; tick_l_a = 1'b0;
    tick_r_b = 1'b0; tick_l_b = 1'b0;
    auto_scroll = 1'b0;

    // Reset state and full scan walk
    cyc(3);
    check("rst_an", an_a, 8'hFF);
    check("rst_seg", seg_a, 7'h7F);
    check("rst_leds", leds_a, 0);
    check("rst_data", data_a, 0);
    check("rst_an_b", an_b, 4'hF);
    rst = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      cyc(1);
      k  = ((c - 1) / 4) % 8;
      ea = ~(8'd1 << k);
      check("scan_an", an_a, ea);
      if (c == 1) check("scan_seg0", seg_a, 7'h40);
      else check("scan_seg", seg_a, hex[(regs_a[0] >> (4*k)) & 32'hF]);
      if (c <= 6) begin
        k  = (c - 1) % 4;
        eb = ~(4'd1 << k);
        pb = {2'b00, regs_b[0]} >> (4*k);
        check("b_an", an_b, eb);
        if (c == 1) check("b_seg0", seg_b, 7'h40);
        else if (k == 3) check("b_blank", seg_b, 7'h7F);
        else check("b_seg", seg_b, hex[pb[3:0]]);
      end
    end

    // Held tick gives one step; data follows one cycle later
    tick_r_a = 1'b1;
    cyc(1);
    check("hold_leds", leds_a, 1);
    check("hold_data_lag", data_a, regs_a[0]);
    cyc(1);
    check("hold_data", data_a, regs_a[1]);
    cyc(18);
    check("hold_once", leds_a, 1);
    tick_r_a = 1'b0;
    cyc(2);

    // Wrap-around on the 5-register viewer
    tick_l_b = 1'b1;
    cyc(1);
    check("wrap_dec", leds_b, 4);
    tick_l_b = 1'b0;
    cyc(2);
    check("wrap_data", data_b, regs_b[4]);
    tick_r_b = 1'b1;
    cyc(1);
    check("wrap_inc", leds_b, 0);
    tick_r_b = 1'b0;
    cyc(1);

    // Walk to index 7, then press both buttons together
    for (int i = 0; i < 6; i++) pulse_r_a();
    check("walk7", leds_a, 7);
    tick_r_a = 1'b1;
    tick_l_a = 1'b1;
    cyc(1);
    check("both_now", leds_a, 7);
    cyc(3);
    check("both_hold", leds_a, 7);
    tick_r_a = 1'b0;
    tick_l_a = 1'b0;
    cyc(1);

    // Live tracking of the selected register
    check("live_old", data_a, regs_a[7]);
    regs_a[7] = 32'h12345678;
    cyc(1);
    check("live_new", data_a, 32'h12345678);

    // Reset while digit 5 is lit
    n = 0;
    while (an_a !== 8'hDF && n < 100) begin
      cyc(1);
      n++;
    end
    check("scan_wait", an_a, 8'hDF);
    rst = 1'b1;
    tick_r_a = 1'b1;
    cyc(1);
    check("mid_idx", leds_a, 0);
    check("mid_an", an_a, 8'hFF);
    check("mid_seg", seg_a, 7'h7F);
    check("mid_data", data_a, 0);
    tick_r_a = 1'b0;
    rst = 1'b0;
    cyc(1);
    check("rel_an", an_a, 8'hFE);
    check("rel_seg", seg_a, 7'h40);
    check("rel_idx", leds_a, 0);

`ifdef AUTO_SCROLL_EN
    // Auto scroll every 10 cycles; coincident manual step wins
    auto_scroll = 1'b1;
    cyc(9);
    check("auto_pre1", leds_a, 0);
    cyc(1);
    check("auto_1", leds_a, 1);
    cyc(9);
    check("auto_pre2", leds_a, 1);
    cyc(1);
    check("auto_2", leds_a, 2);
    cyc(9);
    tick_l_a = 1'b1;
    cyc(1);
    check("auto_man", leds_a, 1);
    tick_l_a = 1'b0;
    cyc(9);
    check("auto_restart", leds_a, 1);
    cyc(1);
    check("auto_3", leds_a, 2);
    auto_scroll = 1'b0;
    cyc(12);
    check("auto_off", leds_a, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
